// File: rtl/uart_pkg.sv
// Shared UART definitions for the word-to-UART transmitter and the UART-to-word receiver.
package uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int WORD_BYTES           = 4;
    localparam int DEFAULT_CLKS_PER_BIT = 128;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronises uart_rx, samples mid-bit, reports bytes, stop-bit errors
// and a one-cycle pulse when the line has idled high for the timeout period.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT      = DEFAULT_CLKS_PER_BIT,
    parameter int IDLE_TIMEOUT_BITS = 20
) (
    input  logic                      clock_in,
    input  logic                      reset,
    input  logic                      uart_rx,
    output logic [UART_DATA_BITS-1:0] byte_data,
    output logic                      byte_valid,
    output logic                      framing_error,
    output logic                      line_idle_timeout
);

    localparam int IDLE_LIMIT = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W      = $clog2(IDLE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_IDLE_MAX = CNT_W'(IDLE_LIMIT);
    localparam logic [3:0]       LAST_BIT     = 4'(UART_DATA_BITS - 1);

    logic [1:0]                sync_q, sync_d;
    logic                      rx_s;
    rx_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] byte_data_q, byte_data_d;
    logic                      byte_valid_q, byte_valid_d;
    logic                      framing_error_q, framing_error_d;
    logic                      timeout_q, timeout_d;

    assign rx_s              = sync_q[1];
    assign byte_data         = byte_data_q;
    assign byte_valid        = byte_valid_q;
    assign framing_error     = framing_error_q;
    assign line_idle_timeout = timeout_q;

    // State, counters, synchroniser and output registers
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_q          <= 2'b11;
            state_q         <= IDLE;
            cnt_q           <= '0;
            bit_cnt_q       <= 4'd0;
            shift_q         <= 8'h00;
            byte_data_q     <= 8'h00;
            byte_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            byte_data_q     <= byte_data_d;
            byte_valid_q    <= byte_valid_d;
            framing_error_q <= framing_error_d;
            timeout_q       <= timeout_d;
        end
    end

    // Next-state and bit-timing decode; cnt doubles as the idle counter while in IDLE
    always_comb begin
        sync_d          = {sync_q[0], uart_rx};
        state_d         = state_q;
        cnt_d           = cnt_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        byte_data_d     = byte_data_q;
        byte_valid_d    = 1'b0;
        framing_error_d = 1'b0;
        timeout_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_IDLE_MAX) begin
                    cnt_d     = cnt_q + 1'b1;
                    timeout_d = (cnt_q == CNT_IDLE_MAX - 1'b1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF_END) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = DATA;
                        bit_cnt_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // Leaving at mid-stop leaves half a bit to catch an immediate next start edge
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d      = IDLE;
                        byte_data_d  = shift_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        state_d         = WAIT_HIGH;
                        framing_error_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HIGH;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/uart_to_register.sv
// Reassembles received UART bytes, least-significant first, into 32-bit words with a valid strobe.
module uart_to_register
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT      = DEFAULT_CLKS_PER_BIT,
    parameter int IDLE_TIMEOUT_BITS = 20
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        uart_rx,
    output logic [31:0] word_data,
    output logic        word_valid,
    output logic        framing_error,
    output logic [1:0]  byte_index
);

    logic [UART_DATA_BITS-1:0] byte_data_s;
    logic                      byte_valid_s;
    logic                      framing_error_s;
    logic                      idle_timeout_s;

    logic [1:0]  byte_index_q, byte_index_d;
    logic [23:0] assembly_q, assembly_d;
    logic [31:0] word_data_q, word_data_d;
    logic        word_valid_q, word_valid_d;

    uart_rx_byte #(
        .CLKS_PER_BIT      (CLKS_PER_BIT),
        .IDLE_TIMEOUT_BITS (IDLE_TIMEOUT_BITS)
    ) u_rx_byte (
        .clock_in          (clock_in),
        .reset             (reset),
        .uart_rx           (uart_rx),
        .byte_data         (byte_data_s),
        .byte_valid        (byte_valid_s),
        .framing_error     (framing_error_s),
        .line_idle_timeout (idle_timeout_s)
    );

    assign word_data     = word_data_q;
    assign word_valid    = word_valid_q;
    assign framing_error = framing_error_s;
    assign byte_index    = byte_index_q;

    // Word assembly registers
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            byte_index_q <= 2'd0;
            assembly_q   <= 24'h000000;
            word_data_q  <= 32'h00000000;
            word_valid_q <= 1'b0;
        end else begin
            byte_index_q <= byte_index_d;
            assembly_q   <= assembly_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
        end
    end

    // Byte slotting; the top byte completes the word straight into word_data
    always_comb begin
        byte_index_d = byte_index_q;
        assembly_d   = assembly_q;
        word_data_d  = word_data_q;
        word_valid_d = 1'b0;
        if (byte_valid_s) begin
            byte_index_d = byte_index_q + 2'd1;
            case (byte_index_q)
                2'd0: assembly_d[7:0]   = byte_data_s;
                2'd1: assembly_d[15:8]  = byte_data_s;
                2'd2: assembly_d[23:16] = byte_data_s;
                2'd3: begin
                    word_data_d  = {byte_data_s, assembly_q};
                    word_valid_d = 1'b1;
                    byte_index_d = 2'd0;
                end
                default: byte_index_d = 2'd0;
            endcase
        end else if (framing_error_s || (idle_timeout_s && (byte_index_q != 2'd0))) begin
            byte_index_d = 2'd0;
            assembly_d   = 24'h000000;
        end else begin
            byte_index_d = byte_index_q;
        end
    end

endmodule

// File: tb/tb_uart_to_register.sv
// Self-checking bench: word vectors table plus hand-written glitch, framing, timeout and reset sequences.
module tb_uart_to_register;

    localparam int CPB = 128;

    logic        clock_in = 1'b0;
    logic        reset    = 1'b1;
    logic        uart_rx  = 1'b1;
    logic [31:0] word_data;
    logic        word_valid;
    logic        framing_error;
    logic [1:0]  byte_index;

    uart_to_register #(.CLKS_PER_BIT(CPB), .IDLE_TIMEOUT_BITS(20)) dut (
        .clock_in      (clock_in),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .word_data     (word_data),
        .word_valid    (word_valid),
        .framing_error (framing_error),
        .byte_index    (byte_index)
    );

    always #5 clock_in = ~clock_in;

    int          checks = 0;
    int          errors = 0;
    int          fe_count = 0;
    int          wv_count = 0;
    int unsigned cyc = 0;
    int unsigned last_wv_cyc = 0;
    int unsigned prev_wv_cyc = 0;
    int          exp_idx = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp;
        int          gap_bits;
        bit          spacing;
    } word_vec_t;

    word_vec_t vecs[3];

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clock_in) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (framing_error) fe_count++;
            if (word_valid) begin
                wv_count++;
                prev_wv_cyc = last_wv_cyc;
                last_wv_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word got %h with none expected", word_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (word_data !== exp_w) begin
                        errors++;
                        $display("FAIL word_data got %h expected %h", word_data, exp_w);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        uart_rx = v;
        repeat (CPB) @(negedge clock_in);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
    endtask

    task automatic send_tracked(input logic [7:0] b);
        send_byte(b, 1'b1);
        exp_idx = (exp_idx + 1) % 4;
        check("byte_index", 32'(byte_index), 32'(exp_idx));
    endtask

    initial begin
        vecs[0] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEADBEEF, 2, 1'b0};
        vecs[1] = '{8'h01, 8'h00, 8'h00, 8'h00, 32'h00000001, 2, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF, 0, 1'b1};

        repeat (5) @(negedge clock_in);
        check("rst_word_data", word_data, 32'h0);
        check("rst_word_valid", 32'(word_valid), 32'h0);
        check("rst_framing_error", 32'(framing_error), 32'h0);
        check("rst_byte_index", 32'(byte_index), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clock_in);

        // Back-to-back words from the table
        for (int i = 0; i < 3; i++) begin
            repeat (vecs[i].gap_bits) bit_time(1'b1);
            exp_q.push_back(vecs[i].exp);
            send_tracked(vecs[i].b0);
            send_tracked(vecs[i].b1);
            send_tracked(vecs[i].b2);
            send_tracked(vecs[i].b3);
            check("words_seen", 32'(wv_count), 32'(i + 1));
            if (vecs[i].spacing) check("word_spacing", last_wv_cyc - prev_wv_cyc, 32'(40 * CPB));
        end
        check("no_framing_error", 32'(fe_count), 32'h0);

        // Start-bit glitch must not insert a byte
        bit_time(1'b1);
        exp_q.push_back(32'h8D7C6B5A);
        send_tracked(8'h5A);
        uart_rx = 1'b0;
        repeat (20) @(negedge clock_in);
        uart_rx = 1'b1;
        repeat (200) @(negedge clock_in);
        check("glitch_byte_index", 32'(byte_index), 32'h1);
        send_tracked(8'h6B);
        send_tracked(8'h7C);
        send_tracked(8'h8D);
        check("glitch_words_seen", 32'(wv_count), 32'd4);
        check("glitch_no_fe", 32'(fe_count), 32'h0);

        // Stop bit low, line held low: one framing error, alignment reset
        send_tracked(8'h77);
        send_byte(8'h55, 1'b0);
        repeat (3) bit_time(1'b0);
        exp_idx = 0;
        check("fe_count", 32'(fe_count), 32'h1);
        check("fe_byte_index", 32'(byte_index), 32'h0);
        repeat (2) bit_time(1'b1);
        exp_q.push_back(32'h04030201);
        send_tracked(8'h01);
        send_tracked(8'h02);
        send_tracked(8'h03);
        send_tracked(8'h04);
        check("fe_words_seen", 32'(wv_count), 32'd5);

        // Idle timeout discards a partial word
        send_tracked(8'hAA);
        send_tracked(8'hBB);
        repeat (19) bit_time(1'b1);
        check("pre_timeout_index", 32'(byte_index), 32'h2);
        repeat (6) bit_time(1'b1);
        exp_idx = 0;
        check("post_timeout_index", 32'(byte_index), 32'h0);
        exp_q.push_back(32'h44332211);
        send_tracked(8'h11);
        send_tracked(8'h22);
        send_tracked(8'h33);
        send_tracked(8'h44);
        check("timeout_words_seen", 32'(wv_count), 32'd6);

        // Reset during the data bits of byte 2
        send_tracked(8'h12);
        send_tracked(8'h34);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        bit_time(1'b1);
        reset = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clock_in);
        check("mid_rst_word_data", word_data, 32'h0);
        check("mid_rst_byte_index", 32'(byte_index), 32'h0);
        check("mid_rst_word_valid", 32'(word_valid), 32'h0);
        reset = 1'b0;
        exp_idx = 0;
        repeat (300) @(negedge clock_in);
        check("post_rst_no_word", 32'(wv_count), 32'd6);
        check("post_rst_no_fe", 32'(fe_count), 32'h1);
        exp_q.push_back(32'hC3C3C3C3);
        for (int k = 0; k < 4; k++) send_tracked(8'hC3);

        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clock_in);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        repeat (50) @(negedge clock_in);
        check("word_data_held", word_data, 32'hC3C3C3C3);
        check("total_words", 32'(wv_count), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_to_register.md
Name: uart_to_register

Overview:
Receive-side counterpart of the team's word-to-UART transmitter. Deserialises an 8N1 UART stream, one bit per CLKS_PER_BIT clocks of clock_in, into bytes. Reassembles every 4 bytes, least-significant byte first, into a 32-bit word and presents it with a one-cycle valid strobe. Sits on the host/peer side of the link, feeding button-array snapshots (or any 32-bit register) into local logic.

Parameters:
CLKS_PER_BIT, 128, clock_in cycles per UART bit (matches the /64 toggle divider on the transmit side); must be even and >= 8
IDLE_TIMEOUT_BITS, 20, consecutive idle-high bit periods after which a partial word is discarded and byte alignment resets

Ports:
clock_in  input  1  system clock
reset  input  1  asynchronous, active-high reset
uart_rx  input  1  serial line, idle high, asynchronous to clock_in
word_data  output  32  last completed word; byte 0 in [7:0], byte 3 in [31:24]
word_valid  output  1  one-cycle pulse when word_data updates
framing_error  output  1  one-cycle pulse when a stop bit samples 0
byte_index  output  2  byte slot the next received byte fills

Behaviour:
- Reset is asynchronous and active-high; clock is clock_in.
- Reset values: word_data=0, word_valid=0, framing_error=0, byte_index=0, state=IDLE, synchroniser flops=1, all counters=0.
- uart_rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Bit-timer cnt counts clock_in cycles within the current state/bit.
- IDLE: rx_s==0 -> START, cnt=0. rx_s==1 -> idle counter increments, saturating.
  - When the idle counter reaches IDLE_TIMEOUT_BITS*CLKS_PER_BIT and byte_index!=0: byte_index<=0 and the partial word is discarded.
  - The idle counter clears whenever the FSM leaves IDLE.
- START: at cnt==CLKS_PER_BIT/2-1 (mid start bit), rx_s==0 -> DATA with cnt=0 and bit_cnt=0; rx_s==1 -> glitch, return to IDLE with no other effect.
- DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into the shift register LSB-first (shift right, new bit at [7]), bit_cnt++, cnt=0. After the 8th sample -> STOP.
- STOP: at cnt==CLKS_PER_BIT-1 (mid stop bit), sample rx_s.
  - rx_s==1: write the byte into assembly[byte_index*8 +: 8] and go to IDLE.
    - If byte_index==3: on the next edge word_data<={byte,assembly[23:0]}, word_valid=1 for exactly one cycle, byte_index<=0.
    - Otherwise byte_index<=byte_index+1.
  - rx_s==0: framing_error=1 for one cycle, byte discarded, byte_index<=0, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. A stuck-low break must not generate repeated bytes.
- Returning to IDLE at mid-stop guarantees detection of a back-to-back start bit. The transmitter sends stop then start immediately, with no extra idle time.
- Latency: word_valid asserts 1 cycle after the mid-stop sample of byte 3, roughly 39.5 bit times plus 2 sync cycles after byte 0's start edge.
- word_data holds its value between strobes. The assembly register is internal and never visible until complete.
- Reset mid-operation: all state returns to reset values immediately; any partial byte or word is lost. No spurious word_valid or framing_error on release.
- Width rules: cnt is $clog2(IDLE_TIMEOUT_BITS*CLKS_PER_BIT+1) bits wide and shared with the idle counter; bit_cnt is 4 bits; byte_index wraps 3->0 only via the completion path.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - UART_DATA_BITS=8;
  - WORD_BYTES=4;
  - the default CLKS_PER_BIT=128, shared with the transmitter.
- One natural sub-module: uart_rx_byte.
  - Contains the synchroniser plus IDLE/START/DATA/STOP/WAIT_HIGH.
  - Outputs: byte_data[7:0], byte_valid, framing_error, line_idle_timeout.
- uart_to_register keeps byte_index, the assembly register and word_data/word_valid.

Test Plan:
- Drive bytes EF,BE,AD,DE back-to-back (no inter-byte idle) at 128 clocks/bit -> exactly one word_valid pulse, word_data=0xDEADBEEF, framing_error never high.
- Two consecutive words 0x00000001 then 0xFFFFFFFF continuously -> two word_valid pulses exactly 40*128 cycles apart with the correct values; byte_index sequence 0,1,2,3,0,1,2,3,0.
- 20-cycle low glitch on idle line -> FSM returns to IDLE; no byte accepted; byte_index unchanged.
- Byte 0x55 with stop bit forced 0, line held low 3 bit times, then bytes 01,02,03,04 -> one framing_error pulse, byte_index=0, then word_data=0x04030201.
- Send bytes AA,BB, idle 25 bit times, then 11,22,33,44 -> byte_index returns to 0 after 20*128 idle cycles; word_data=0x44332211, not containing AA/BB.
- Assert reset in the middle of byte 2's data bits, release, send 4 bytes 0xC3 -> no word_valid before the new bytes; word_data=0xC3C3C3C3.
